// File: rtl/bit_serial_mac_mult.sv
// Bit-serial sign-magnitude neuron x weight multiplier with start/busy/out_valid handshake.
// Optional build macro MULT_ROUND_EN selects round-half-up instead of truncation.
module bit_serial_mac_mult #(
  parameter int DATA_W   = 16,
  parameter int INT_W    = 5,
  parameter int FRAC_W   = 10,
  parameter int WEIGHT_W = 16,
  parameter int WFRAC_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] neuron_in,
  input  logic              weight_bit,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              overflow
);

  localparam int MAG_W  = DATA_W - 1;
  localparam int WMAG_W = WEIGHT_W - 1;
  localparam int ACC_W  = MAG_W + WMAG_W;
  localparam int SUM_W  = ACC_W + 1;
  localparam int RES_W  = SUM_W - WFRAC_W;
  localparam int RMAG_W = INT_W + FRAC_W;
  localparam int CNT_W  = $clog2(WEIGHT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WEIGHT_W - 2);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;

  state_t             state;
  logic [MAG_W-1:0]   mag_r;
  logic               sign_r;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [SUM_W-1:0]   sum;
  logic [RES_W-1:0]   res_full;
  logic               sat;
  logic [RMAG_W-1:0]  res_mag;
  logic               res_sign;

  // Extra top bit of sum captures the rounding carry so it reaches the saturation check.
  always_comb begin
    sum = {1'b0, acc};
`ifdef MULT_ROUND_EN
    sum = sum + (SUM_W'(1) << (WFRAC_W - 1));
`endif
    res_full = RES_W'(sum >> WFRAC_W);
    sat      = |res_full[RES_W-1:RMAG_W];
    res_mag  = sat ? '1 : res_full[RMAG_W-1:0];
    res_sign = sign_r & (|res_mag);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mag_r     <= '0;
      sign_r    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_r  <= neuron_in[MAG_W-1:0];
            sign_r <= neuron_in[DATA_W-1] ^ weight_bit;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= (acc << 1) + (weight_bit ? ACC_W'(mag_r) : '0);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ROUND;
        end
        ROUND: begin
          out       <= {res_sign, res_mag};
          overflow  <= sat;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_mac_mult.sv
// Directed self-checking bench for bit_serial_mac_mult at default parameters.
module tb_bit_serial_mac_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] neuron_in;
  logic        weight_bit;
  logic        busy;
  logic        out_valid;
  logic [15:0] out;
  logic        overflow;

  int unsigned total  = 0;
  int unsigned passed = 0;

  bit_serial_mac_mult dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .neuron_in  (neuron_in),
    .weight_bit (weight_bit),
    .busy       (busy),
    .out_valid  (out_valid),
    .out        (out),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge where out_valid should be high.
  task automatic mult(input logic [15:0] n, input logic [15:0] w, input logic glitch);
    start      = 1'b1;
    neuron_in  = n;
    weight_bit = w[15];
    for (int i = 14; i >= 0; i--) begin
      @(negedge clk);
      if (i == 14) check("busy_shift", {15'b0, busy}, 16'h0001);
      start      = glitch && (i == 10);
      neuron_in  = glitch ? 16'h7FFF : ~n;
      weight_bit = w[i];
    end
    start = 1'b0;
    @(negedge clk);
    check("no_early_valid", {15'b0, out_valid}, 16'h0000);
    weight_bit = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp_out, input logic exp_ov);
    check({tag, "_valid"}, {15'b0, out_valid}, 16'h0001);
    check({tag, "_busy"},  {15'b0, busy},      16'h0000);
    check({tag, "_out"},   out,                exp_out);
    check({tag, "_ovf"},   {15'b0, overflow},  {15'b0, exp_ov});
  endtask

  initial begin
    logic seen_valid;
    logic [15:0] round_exp;
    reset      = 1'b0;
    start      = 1'b0;
    neuron_in  = '0;
    weight_bit = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out",   out,                16'h0000);
    check("rst_ovf",   {15'b0, overflow},  16'h0000);
    check("rst_valid", {15'b0, out_valid}, 16'h0000);
    check("rst_busy",  {15'b0, busy},      16'h0000);
    reset = 1'b1;
    @(negedge clk);

    mult(16'h0400, 16'h0400, 1'b0);
    check_result("one_x_one", 16'h0400, 1'b0);
    @(negedge clk);
    check("valid_pulse", {15'b0, out_valid}, 16'h0000);

    mult(16'h8800, 16'h0600, 1'b0);
    check_result("neg2_x_1p5", 16'h8C00, 1'b0);
    @(negedge clk);

    mult(16'h7C00, 16'h0800, 1'b0);
    check_result("sat", 16'h7FFF, 1'b1);
    mult(16'h0400, 16'h0400, 1'b0);
    check_result("sat_clear", 16'h0400, 1'b0);
    @(negedge clk);

    mult(16'h8400, 16'h0000, 1'b0);
    check_result("negzero_w0", 16'h0000, 1'b0);
    @(negedge clk);
    mult(16'h8400, 16'h8000, 1'b0);
    check_result("negzero_wn0", 16'h0000, 1'b0);
    @(negedge clk);

`ifdef MULT_ROUND_EN
    round_exp = 16'h0001;
`else
    round_exp = 16'h0000;
`endif
    mult(16'h0001, 16'h0200, 1'b0);
    check_result("round_half", round_exp, 1'b0);
    @(negedge clk);

    mult(16'h0400, 16'h0600, 1'b0);
    check_result("pre_reset", 16'h0600, 1'b0);
    @(negedge clk);

    // Abort a multiply with reset after five cycles; no result may appear.
    start      = 1'b1;
    neuron_in  = 16'h0400;
    weight_bit = 1'b0;
    @(negedge clk);
    start      = 1'b0;
    weight_bit = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy",  {15'b0, busy},      16'h0000);
    check("abort_out",   out,                16'h0000);
    check("abort_valid", {15'b0, out_valid}, 16'h0000);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    check("abort_no_valid", {15'b0, seen_valid}, 16'h0000);

    mult(16'h0400, 16'h0400, 1'b1);
    check_result("restart_glitch", 16'h0400, 1'b0);
    mult(16'h8800, 16'h0600, 1'b0);
    check_result("back_to_back", 16'h8C00, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bit_serial_mac_mult.md
Name: bit_serial_mac_mult

Overview:
- Parametrised successor to the team's 16-bit bit-serial neuron×weight multiplier.
- Multiplies a sign-magnitude fixed-point neuron value by a sign-magnitude weight streamed one bit per cycle, sign bit first, then magnitude bits MSB first.
- Adds over the previous generation: latched operand, start/busy/out_valid handshake, parametrised formats, saturation with an overflow flag, and negative-zero suppression.
- Sits in the accelerator datapath between the weight bit-stream source and the neuron accumulate stage.

Parameters:
- DATA_W, 16: neuron and result width; 1 sign bit + INT_W + FRAC_W magnitude bits.
- INT_W, 5: integer bits of neuron and result (DATA_W = 1 + INT_W + FRAC_W).
- FRAC_W, 10: fraction bits of neuron and result.
- WEIGHT_W, 16: total serial weight width, sign bit included.
- WFRAC_W, 10: fraction bits of the weight magnitude.

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-low
- start  in  1  begin a multiply; sampled only in IDLE
- neuron_in  in  DATA_W  sign-magnitude neuron; latched on the accepted start
- weight_bit  in  1  serial weight; sign on the start cycle, then magnitude MSB first
- busy  out  1  high while state != IDLE
- out_valid  out  1  one-cycle pulse when out/overflow update
- out  out  DATA_W  sign-magnitude product, held until the next result
- overflow  out  1  result saturated; held alongside out

Behaviour:
- Reset (reset==0 at a posedge), mid-operation included:
  - state=IDLE; out=0, out_valid=0, overflow=0, busy=0.
  - Accumulator, counter and latched operands cleared.
  - An in-flight multiply is discarded with no out_valid.
- FSM states: IDLE, SHIFT, ROUND.
- IDLE & start at edge E0:
  - Latch neuron magnitude and sign_r = neuron_in[DATA_W-1] ^ weight_bit.
  - acc=0, cnt=0; go to SHIFT.
- SHIFT, edges E1..E(WEIGHT_W-1):
  - acc <= (acc<<1) + (weight_bit ? mag : 0); cnt++.
  - After the edge consuming the last magnitude bit (cnt==WEIGHT_W-2), go to ROUND.
- acc width: (DATA_W-1)+(WEIGHT_W-1) bits (30 at defaults). The product has FRAC_W+WFRAC_W fraction bits.
- ROUND, edge E(WEIGHT_W):
  - res = acc >> WFRAC_W, with rounding per the optional feature.
  - If any bit of res above bit INT_W+FRAC_W-1 is set, or rounding carries out: magnitude = all ones, overflow=1. Otherwise overflow=0.
  - If magnitude==0, the sign is forced to 0 (no negative zero).
  - out, overflow and out_valid=1 registered; go to IDLE.
- Timing and handshake:
  - out_valid is high for exactly one cycle.
  - Latency is start edge to out_valid edge = WEIGHT_W cycles (16).
  - start asserted in the same cycle as out_valid is accepted (state is IDLE), giving one result every WEIGHT_W+1 cycles.
  - start while busy is ignored: no effect on the latched operand or the stream.
  - neuron_in may change freely after the accepted start.
  - weight_bit is don't-care outside the start cycle and SHIFT.

Optional Feature:
- Macro: MULT_ROUND_EN.
- Defined: round-half-up. res = (acc + (1<<(WFRAC_W-1))) >> WFRAC_W, with the carry feeding the overflow check.
- Undefined: truncate, res = acc >> WFRAC_W, matching the previous-generation multiplier.
- Ports and latency are identical in both builds.

Test Plan:
- neuron_in=0x0400 (1.0), weight 0x0400 (1.0) -> out_valid 16 cycles after start, out=0x0400, overflow=0, busy low the cycle out_valid is high.
- neuron_in=0x8800 (-2.0), weight 0x0600 (1.5) -> out=0x8C00 (-3.0), overflow=0.
- neuron_in=0x7C00 (31.0), weight 0x0800 (2.0) -> out=0x7FFF, overflow=1; the next multiply 0x0400×0x0400 clears overflow.
- neuron_in=0x8400 (-1.0), weight 0x0000 -> out=0x0000 (sign suppressed); weight 0x8000 (-0) -> out=0x0000.
- neuron_in=0x0001, weight 0x0200 (0.5) -> out=0x0000 with MULT_ROUND_EN undefined; out=0x0001 with it defined.
- Start, then reset low at cycle 5 -> busy=0, out=0, no out_valid. Restart 0x0400×0x0400 -> correct 0x0400. A second start pulse mid-SHIFT is ignored, and back-to-back start on the out_valid cycle is accepted.
